// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer feeding the PC-increment adder.
// Issues word fetches over a req/ready handshake and hands words to decode via a valid/ready slot.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] pc_next_in,
   output logic [31:0] pc_out,
   output logic [31:0] step_out,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   input  logic        decode_ready,
   output logic        misaligned
);

   // state | meaning
   // BOOT  | first cycle after reset release, no fetch issued
   // FETCH | normal sequential fetch
   // DRAIN | waiting to discard one response made stale by a redirect
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic        outstanding;
   logic [31:0] drain_addr;
   logic        skid_valid;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;

   logic        slot_free;
   logic        issue;
   logic        accept;
   logic        consume;

   assign slot_free = !instr_valid || decode_ready;
   assign issue     = (state == FETCH) && !stall && !redirect && slot_free && !skid_valid;
   assign imem_req  = outstanding || issue;
   assign accept    = (state == FETCH) && imem_req && imem_ready && !redirect;
   assign consume   = instr_valid && decode_ready;

   assign step_out  = PC_STEP;
   // The stale request must keep its original address while pc_out already points at the target.
   assign imem_addr = (state == DRAIN) ? drain_addr : pc_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         pc_out      <= RESET_PC;
         outstanding <= 1'b0;
         drain_addr  <= 32'h0;
         instr_valid <= 1'b0;
         instr_out   <= NOP_INSTR;
         instr_pc    <= 32'h0;
         skid_valid  <= 1'b0;
         skid_instr  <= 32'h0;
         skid_pc     <= 32'h0;
         misaligned  <= 1'b0;
      end else begin
         misaligned <= 1'b0;
         if (imem_req) begin
            outstanding <= !imem_ready;
         end
         if (redirect) begin
            pc_out     <= {redirect_pc[31:2], 2'b00};
            misaligned <= |redirect_pc[1:0];
         end

         case (state)
            BOOT: begin
               state <= FETCH;
            end

            FETCH: begin
               if (redirect) begin
                  instr_valid <= 1'b0;
                  instr_out   <= NOP_INSTR;
                  skid_valid  <= 1'b0;
                  if (outstanding && !imem_ready) begin
                     state      <= DRAIN;
                     drain_addr <= pc_out;
                  end
               end else begin
                  if (accept) begin
                     pc_out <= pc_next_in;
                  end
                  if (accept && slot_free) begin
                     instr_valid <= 1'b1;
                     instr_out   <= imem_rdata;
                     instr_pc    <= pc_out;
                  end else if (accept) begin
                     skid_valid <= 1'b1;
                     skid_instr <= imem_rdata;
                     skid_pc    <= pc_out;
                  end else if (consume) begin
                     if (skid_valid) begin
                        instr_out  <= skid_instr;
                        instr_pc   <= skid_pc;
                        skid_valid <= 1'b0;
                     end else begin
                        instr_valid <= 1'b0;
                        instr_out   <= NOP_INSTR;
                     end
                  end
               end
            end

            DRAIN: begin
               if (imem_ready) begin
                  state <= FETCH;
               end
            end

            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table from reset plus hand sequences
// for wait states, decode backpressure, redirect/drain, wrap-around and mid-transaction reset.
module tb_pc_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] TAG = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] pc_next_in;
   logic [31:0] pc_out;
   logic [31:0] step_out;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        decode_ready = 1'b1;
   logic        misaligned;

   logic        zw = 1'b1;
   logic        man_ready = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Adder and memory environment: zero-wait mode answers every request in the same cycle.
   assign pc_next_in = pc_out + step_out;
   assign imem_ready = zw ? imem_req : man_ready;
   assign imem_rdata = imem_addr + TAG;

   pc_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .pc_next_in(pc_next_in), .pc_out(pc_out), .step_out(step_out),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
      .decode_ready(decode_ready), .misaligned(misaligned)
   );

   typedef struct {
      logic        s;
      logic        d;
      logic        r;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic        e_v;
      logic [31:0] e_ipc;
      logic        e_mis;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic d, input logic r, input logic [31:0] rp,
                       input logic rdy);
      @(negedge clk);
      stall        = s;
      decode_ready = d;
      redirect     = r;
      redirect_pc  = rp;
      man_ready    = rdy;
      #1;
   endtask

   task automatic chk_slot(input string nm, input logic v, input logic [31:0] ipc);
      chk({nm, ".valid"}, instr_valid, v);
      chk({nm, ".instr"}, instr_out, v ? ipc + TAG : NOP);
      if (v) chk({nm, ".ipc"}, instr_pc, ipc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          s  d  r  rpc           req addr          pc            v  ipc           mis
      vt[0]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,32'h0,   32'h0,   1'b0,32'h0,   1'b0};
      vt[1]  = '{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h0,   32'h0,   1'b0,32'h0,   1'b0};
      vt[2]  = '{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h4,   32'h4,   1'b1,32'h0,   1'b0};
      vt[3]  = '{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h8,   32'h8,   1'b1,32'h4,   1'b0};
      vt[4]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'hC,   32'hC,   1'b1,32'h8,   1'b0};
      vt[5]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'hC,   32'hC,   1'b1,32'h8,   1'b0};
      vt[6]  = '{1'b0,1'b1,1'b0,32'h0,   1'b1,32'hC,   32'hC,   1'b1,32'h8,   1'b0};
      vt[7]  = '{1'b1,1'b1,1'b0,32'h0,   1'b0,32'h10,  32'h10,  1'b1,32'hC,   1'b0};
      vt[8]  = '{1'b1,1'b1,1'b0,32'h0,   1'b0,32'h10,  32'h10,  1'b0,32'h0,   1'b0};
      vt[9]  = '{1'b0,1'b1,1'b1,32'h203, 1'b0,32'h10,  32'h10,  1'b0,32'h0,   1'b0};
      vt[10] = '{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h200, 32'h200, 1'b0,32'h0,   1'b1};
      vt[11] = '{1'b1,1'b1,1'b0,32'h0,   1'b0,32'h204, 32'h204, 1'b1,32'h200, 1'b0};
      vt[12] = '{1'b1,1'b1,1'b0,32'h0,   1'b0,32'h204, 32'h204, 1'b0,32'h0,   1'b0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst.pc", pc_out, 32'h0);
      chk("rst.step", step_out, 32'd4);
      chk("rst.req", imem_req, 1'b0);
      chk("rst.mis", misaligned, 1'b0);
      chk_slot("rst", 1'b0, 32'h0);

      // Table: zero-wait memory from reset release
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         if (i > 0) @(negedge clk);
         stall        = vt[i].s;
         decode_ready = vt[i].d;
         redirect     = vt[i].r;
         redirect_pc  = vt[i].rpc;
         #1;
         chk($sformatf("vec%0d.req", i), imem_req, vt[i].e_req);
         chk($sformatf("vec%0d.addr", i), imem_addr, vt[i].e_addr);
         chk($sformatf("vec%0d.pc", i), pc_out, vt[i].e_pc);
         chk($sformatf("vec%0d.mis", i), misaligned, vt[i].e_mis);
         chk_slot($sformatf("vec%0d", i), vt[i].e_v, vt[i].e_ipc);
      end

      // Wait-state memory with stall raised mid-wait
      zw = 1'b0;
      step(1, 1, 1, 32'h10, 0);
      step(0, 1, 0, 0, 0); chk("lat.req0", imem_req, 1); chk("lat.addr0", imem_addr, 32'h10);
      step(1, 1, 0, 0, 0); chk("lat.req1", imem_req, 1); chk("lat.addr1", imem_addr, 32'h10);
      step(1, 1, 0, 0, 0); chk("lat.req2", imem_req, 1); chk("lat.addr2", imem_addr, 32'h10);
      step(1, 1, 0, 0, 1); chk("lat.req3", imem_req, 1); chk("lat.addr3", imem_addr, 32'h10);
      step(1, 1, 0, 0, 0); chk("lat.req4", imem_req, 0); chk("lat.pc", pc_out, 32'h14);
      chk_slot("lat", 1, 32'h10);

      // Decode backpressure with zero-wait memory: one word, then no issue until decode drains
      zw = 1'b1;
      step(0, 0, 0, 0, 0); chk("bp.req0", imem_req, 1); chk("bp.addr0", imem_addr, 32'h14);
      chk("bp.v0", instr_valid, 0);
      step(0, 0, 0, 0, 0); chk("bp.req1", imem_req, 0); chk_slot("bp1", 1, 32'h14);
      chk("bp.pc", pc_out, 32'h18);
      step(0, 0, 0, 0, 0); chk("bp.req2", imem_req, 0); chk_slot("bp2", 1, 32'h14);
      step(0, 1, 0, 0, 0); chk("bp.req3", imem_req, 1); chk("bp.addr3", imem_addr, 32'h18);
      chk_slot("bp3", 1, 32'h14);
      step(1, 1, 0, 0, 0); chk("bp.req4", imem_req, 0); chk_slot("bp4", 1, 32'h18);

      // Redirect while a fetch is outstanding: drain the stale response
      zw = 1'b0;
      step(1, 1, 1, 32'h20, 0); chk("dr.v0", instr_valid, 0);
      step(0, 1, 0, 0, 0); chk("dr.req0", imem_req, 1); chk("dr.addr0", imem_addr, 32'h20);
      step(0, 1, 1, 32'h100, 0); chk("dr.req1", imem_req, 1); chk("dr.addr1", imem_addr, 32'h20);
      step(0, 1, 0, 0, 0); chk("dr.req2", imem_req, 1); chk("dr.addr2", imem_addr, 32'h20);
      chk("dr.pc2", pc_out, 32'h100); chk_slot("dr2", 0, 0);
      step(0, 1, 0, 0, 1); chk("dr.req3", imem_req, 1); chk("dr.addr3", imem_addr, 32'h20);
      step(0, 1, 0, 0, 0); chk_slot("dr4", 0, 0);
      chk("dr.req4", imem_req, 1); chk("dr.addr4", imem_addr, 32'h100);
      step(0, 1, 0, 0, 1); chk("dr.req5", imem_req, 1); chk("dr.addr5", imem_addr, 32'h100);
      step(1, 1, 0, 0, 0); chk_slot("dr6", 1, 32'h100); chk("dr.pc6", pc_out, 32'h104);

      // Redirect coinciding with imem_ready: response dropped, no drain
      step(0, 1, 0, 0, 0); chk("rr.req0", imem_req, 1); chk("rr.addr0", imem_addr, 32'h104);
      step(0, 1, 1, 32'h300, 1);
      step(1, 1, 0, 0, 0); chk("rr.req1", imem_req, 0); chk("rr.pc1", pc_out, 32'h300);
      chk_slot("rr1", 0, 0);
      step(0, 1, 0, 0, 1); chk("rr.req2", imem_req, 1); chk("rr.addr2", imem_addr, 32'h300);

      // PC wrap-around
      zw = 1'b1;
      step(1, 1, 1, 32'hFFFF_FFFC, 0); chk_slot("wr0", 1, 32'h300);
      step(0, 1, 0, 0, 0); chk("wr.req", imem_req, 1); chk("wr.addr", imem_addr, 32'hFFFF_FFFC);
      step(1, 1, 0, 0, 0); chk("wr.pc", pc_out, 32'h0); chk_slot("wr1", 1, 32'hFFFF_FFFC);

      // Reset in the middle of a wait; late ready must be ignored
      zw = 1'b0;
      step(1, 1, 1, 32'h40, 0);
      step(0, 1, 0, 0, 0); chk("mr.req0", imem_req, 1); chk("mr.addr0", imem_addr, 32'h40);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mr.pc1", pc_out, 32'h0); chk("mr.req1", imem_req, 0); chk_slot("mr1", 0, 0);
      step(0, 1, 0, 0, 1); chk("mr.req2", imem_req, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mr.req3", imem_req, 0); chk("mr.pc3", pc_out, 32'h0);
      step(1, 1, 0, 0, 0); chk("mr.req4", imem_req, 0); chk_slot("mr4", 0, 0);
      step(0, 1, 0, 0, 0); chk("mr.req5", imem_req, 1); chk("mr.addr5", imem_addr, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
